// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Arbitrates the single CPU memory bus between four requesters
// (0 = instruction fetch, 1 = instruction execute, 2 = interrupt sequencer,
// 3 = OAM DMA). At most one request is accepted per cycle. Priority is
// DMA > INT > IE > IF, with a starvation guard that force-grants IF. A
// requester can lock the bus across several transactions. The accepted
// request is registered onto the bus, and read data is routed back to
// the requester that issued the read.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req/we/lock[3:0]  per-requester request, write enable, hold-lock
//   addr[63:0]        requester i address on [16i+15:16i]
//   wdata[31:0]       requester i write data on [8i+7:8i]
//   gnt[3:0]          one-hot combinational grant (accept at next edge)
//   rvalid[3:0]       one-hot one-cycle read-response pulse
//   rdata[7:0]        shared read data, valid with rvalid
//   mem_addr, mem_data_out, mem_write_en   registered bus outputs
//   mem_data_in       bus read data, RD_LATENCY cycles after mem_addr
//   bus_owner[1:0]    index of the last accepted requester
//   bus_locked        high while the bus is locked (FSM in LOCKED)
//
// Handshake: req[i] is a valid that the requester holds, together with
// addr/we/wdata/lock, until it sees gnt[i] high. gnt[i] is the ready; the
// transaction is accepted at the clock edge that ends a cycle in which both
// are high. The requester may present its next request in the following cycle.
module cpu_mem_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  we,
  input  logic [3:0]  lock,
  input  logic [63:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  rvalid,
  output logic [7:0]  rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_in,
  output logic [1:0]  bus_owner,
  output logic        bus_locked
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [1:0]       lock_id;
  logic [1:0]       lock_id_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             starve_fire;
  logic [3:0]       gnt_raw;
  logic             accept;
  logic [1:0]       win_id;
  logic [15:0]      win_addr;
  logic [7:0]       win_wdata;
  logic             win_we;

  // Read tag pipeline: {valid, requester id}. Stage RD_LATENCY lines up
  // with the cycle in which mem_data_in carries the data for that read.
  logic [2:0] tag_pipe [0:RD_LATENCY];

  assign starve_fire = (starve_cnt == STARVE_LIM);

  always_comb begin
    gnt_raw = 4'b0000;
    if (state == ST_LOCKED) begin
      if (req[lock_id]) gnt_raw[lock_id] = 1'b1;
    end else if (starve_fire && req[0]) begin
      gnt_raw = 4'b0001;
    end else if (req[3]) begin
      gnt_raw = 4'b1000;
    end else if (req[2]) begin
      gnt_raw = 4'b0100;
    end else if (req[1]) begin
      gnt_raw = 4'b0010;
    end else if (req[0]) begin
      gnt_raw = 4'b0001;
    end
  end

  // No grant is advertised while reset is held.
  assign gnt    = rst ? gnt_raw : 4'b0000;
  assign accept = |gnt_raw;

  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_raw[i]) win_id = 2'(i);
    end
  end

  assign win_addr  = addr[{win_id, 4'b0000} +: 16];
  assign win_wdata = wdata[{win_id, 3'b000} +: 8];
  assign win_we    = we[win_id];

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    if (state == ST_IDLE) begin
      if (accept && lock[win_id]) begin
        state_nxt   = ST_LOCKED;
        lock_id_nxt = win_id;
      end
    end else begin
      // Release on an unlocking accept, or when the owner goes idle with
      // its lock dropped.
      if (accept && !lock[lock_id]) begin
        state_nxt = ST_IDLE;
      end else if (!req[lock_id] && !lock[lock_id]) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // IF wait counter: only counts while arbitration is open; frozen while
  // another requester holds the lock, saturates at the guard threshold.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!req[0] || gnt_raw[0]) begin
      starve_nxt = '0;
    end else if ((state == ST_IDLE) && !starve_fire) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lock_id    <= 2'd0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lock_id    <= lock_id_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr     <= 16'h0000;
      mem_data_out <= 8'h00;
      mem_write_en <= 1'b0;
      bus_owner    <= 2'd0;
    end else if (accept) begin
      mem_addr     <= win_addr;
      mem_write_en <= win_we;
      bus_owner    <= win_id;
      if (win_we) mem_data_out <= win_wdata;
    end else begin
      mem_write_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LATENCY; i++) tag_pipe[i] <= 3'b000;
      rvalid <= 4'b0000;
      rdata  <= 8'h00;
    end else begin
      tag_pipe[0] <= {accept && !win_we, win_id};
      for (int i = 1; i <= RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (tag_pipe[RD_LATENCY][2]) begin
        rvalid <= 4'b0001 << tag_pipe[RD_LATENCY][1:0];
        rdata  <= mem_data_in;
      end else begin
        rvalid <= 4'b0000;
      end
    end
  end

  assign bus_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;

  localparam int RD_LATENCY = 1;
  localparam int STARVE_MAX = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [3:0]  lock = '0;
  logic [63:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_write_en;
  logic [7:0]  mem_data_in;
  logic [1:0]  bus_owner;
  logic        bus_locked;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.RD_LATENCY(RD_LATENCY), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .bus_owner(bus_owner), .bus_locked(bus_locked)
  );

  // ---------------- bus memory (one-cycle synchronous read) ----------------
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] bus_mem [int];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    rd_q <= bus_mem.exists(int'(mem_addr)) ? bus_mem[int'(mem_addr)] : init_val(mem_addr);
    if (mem_write_en) bus_mem[int'(mem_addr)] = mem_data_out;
  end
  assign mem_data_in = rd_q;

  // ---------------- counters / checker ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [int];
  logic [41:0] exp_q [$];     // {due cycle, requester id, read data}
  logic        m_locked = 1'b0;
  int          m_id = 0;
  int          m_wait = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_dout = '0;
  logic        m_we = 1'b0;
  logic [1:0]  m_owner = '0;

  int gnt_hist [4][$];        // cycles in which each requester was granted
  int lock_hi = 0;

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [3:0] model_gnt();
    logic [3:0] one;
    one = 4'b0001;
    if (m_locked) return req[m_id] ? (one << m_id) : 4'b0000;
    if (m_wait >= STARVE_MAX && req[0]) return 4'b0001;
    for (int i = 3; i >= 0; i--) if (req[i]) return one << i;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_locked = 1'b0; m_id = 0; m_wait = 0;
    m_addr = '0; m_dout = '0; m_we = 1'b0; m_owner = '0;
  endtask

  // ---------------- requester drivers ----------------
  logic [25:0] txq [4][$];    // {lock, we, wdata, addr}
  logic [3:0]  idle_lock = '0;
  logic [3:0]  g_seen = '0;

  function automatic logic [25:0] tx(input logic lk, input logic w,
                                     input logic [7:0] d, input logic [15:0] a);
    return {lk, w, d, a};
  endfunction

  task automatic present();
    logic [25:0] t;
    for (int i = 0; i < 4; i++) begin
      if (txq[i].size() > 0) begin
        t = txq[i][0];
        req[i] = 1'b1; lock[i] = t[25]; we[i] = t[24];
        wdata[8*i +: 8] = t[23:16]; addr[16*i +: 16] = t[15:0];
      end else begin
        req[i] = 1'b0; lock[i] = idle_lock[i];
        we[i] = 1'($urandom_range(0, 1));
        addr[16*i +: 16] = 16'($urandom);
      end
    end
  endtask

  // Compare this cycle's outputs to the model, then advance the model.
  task automatic check_cycle();
    logic [3:0]  eg;
    logic [41:0] e;
    logic [3:0]  one;
    logic [15:0] a;
    logic [7:0]  d;
    int          wi;
    one = 4'b0001;
    eg = model_gnt();
    check_eq("gnt", gnt, eg);
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_write_en", mem_write_en, m_we);
    if (m_we) check_eq("mem_data_out", mem_data_out, m_dout);
    check_eq("bus_owner", bus_owner, m_owner);
    check_eq("bus_locked", bus_locked, m_locked);
    if (bus_locked) lock_hi++;
    if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
      e = exp_q.pop_front();
      check_eq("rvalid", rvalid, one << e[9:8]);
      check_eq("rdata", rdata, e[7:0]);
    end else begin
      check_eq("rvalid_idle", rvalid, 4'b0000);
    end
    wi = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) wi = i;
    if (eg != 4'b0000) begin
      a = addr[16*wi +: 16];
      d = wdata[8*wi +: 8];
      m_addr = a; m_owner = 2'(wi); m_we = we[wi];
      gnt_hist[wi].push_back(cyc);
      if (we[wi]) begin
        m_dout = d;
        ref_mem[int'(a)] = d;
      end else begin
        exp_q.push_back({32'(cyc + 2 + RD_LATENCY), 2'(wi), ref_read(a)});
      end
    end else begin
      m_we = 1'b0;
    end
    if (!req[0] || eg[0]) m_wait = 0;
    else if (!m_locked && m_wait < STARVE_MAX) m_wait++;
    if (m_locked) begin
      if ((eg != 4'b0000 && !lock[m_id]) || (!req[m_id] && !lock[m_id])) m_locked = 1'b0;
    end else if (eg != 4'b0000 && lock[wi]) begin
      m_locked = 1'b1; m_id = wi;
    end
  endtask

  task automatic step();
    @(negedge clk);
    g_seen = gnt;
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (g_seen[i] && txq[i].size() > 0) void'(txq[i].pop_front());
    present();
  endtask

  function automatic logic busy();
    for (int i = 0; i < 4; i++) if (txq[i].size() > 0) return 1'b1;
    return exp_q.size() > 0;
  endfunction

  task automatic drain();
    int k;
    k = 0;
    while (busy() && k < 300) begin
      step();
      k++;
    end
    check_eq("drain_timeout", k < 300, 1'b1);
    repeat (RD_LATENCY + 3) step();
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) gnt_hist[i].delete();
    lock_hi = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, gnt, 4'b0000);
    check_eq({tag, "_rvalid"}, rvalid, 4'b0000);
    check_eq({tag, "_rdata"}, rdata, 8'h00);
    check_eq({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check_eq({tag, "_mem_data_out"}, mem_data_out, 8'h00);
    check_eq({tag, "_mem_write_en"}, mem_write_en, 1'b0);
    check_eq({tag, "_bus_owner"}, bus_owner, 2'd0);
    check_eq({tag, "_bus_locked"}, bus_locked, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    present();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single IE read of 0x1234 returning 0xA5 (DMA places the byte first).
    txq[3].push_back(tx(1'b0, 1'b1, 8'hA5, 16'h1234));
    drain();
    clear_hist();
    txq[1].push_back(tx(1'b0, 1'b0, 8'h00, 16'h1234));
    drain();
    check_eq("ie_read_granted", gnt_hist[1].size(), 1);

    // IF, IE and DMA together: order DMA, IE, IF.
    clear_hist();
    txq[0].push_back(tx(1'b0, 1'b0, 8'h00, 16'h0040));
    txq[1].push_back(tx(1'b0, 1'b0, 8'h00, 16'h0041));
    txq[3].push_back(tx(1'b0, 1'b1, 8'h55, 16'h2004));
    drain();
    check_eq("order_dma_ie", gnt_hist[1][0] - gnt_hist[3][0], 1);
    check_eq("order_ie_if", gnt_hist[0][0] - gnt_hist[1][0], 1);

    // INT locked push sequence while IE requests continuously.
    clear_hist();
    txq[2].push_back(tx(1'b1, 1'b1, 8'hC1, 16'h01FD));
    txq[2].push_back(tx(1'b1, 1'b1, 8'hC2, 16'h01FC));
    txq[2].push_back(tx(1'b0, 1'b1, 8'hC3, 16'h01FB));
    for (int i = 0; i < 5; i++) txq[1].push_back(tx(1'b0, 1'b0, 8'h00, 16'(16'h01FB + i)));
    drain();
    check_eq("lock_ie_after_push", gnt_hist[1][0] - gnt_hist[2][2], 1);
    check_eq("lock_push_consecutive", gnt_hist[2][2] - gnt_hist[2][0], 2);
    check_eq("lock_cycles", lock_hi, 2);

    // Back-to-back reads from different requesters.
    txq[3].push_back(tx(1'b0, 1'b1, 8'h11, 16'h8000));
    txq[3].push_back(tx(1'b0, 1'b1, 8'h22, 16'h8001));
    drain();
    clear_hist();
    txq[0].push_back(tx(1'b0, 1'b0, 8'h00, 16'h8000));
    step();
    txq[1].push_back(tx(1'b0, 1'b0, 8'h00, 16'h8001));
    drain();
    check_eq("b2b_consecutive", gnt_hist[1][0] - gnt_hist[0][0], 1);

    // Starvation guard: DMA streams unlocked writes while IF waits.
    clear_hist();
    for (int i = 0; i < 24; i++) txq[3].push_back(tx(1'b0, 1'b1, 8'(i), 16'(16'h3000 + i)));
    txq[0].push_back(tx(1'b0, 1'b0, 8'h00, 16'h3000));
    txq[0].push_back(tx(1'b0, 1'b0, 8'h00, 16'h3001));
    drain();
    check_eq("starve_if_wait", gnt_hist[0][0] - gnt_hist[3][0], STARVE_MAX);
    check_eq("starve_dma_resume", gnt_hist[3][STARVE_MAX] - gnt_hist[0][0], 1);
    check_eq("starve_cleared", gnt_hist[0][1] - gnt_hist[0][0], STARVE_MAX + 1);

    // Reset one cycle after a read accept: pending response is discarded.
    clear_hist();
    txq[1].push_back(tx(1'b0, 1'b0, 8'h00, 16'h0077));
    k = 0;
    while (gnt_hist[1].size() == 0 && k < 20) begin
      step();
      k++;
    end
    check_eq("rst_setup_gnt", gnt_hist[1].size(), 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) txq[i].delete();
    present();
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) step();

    // Randomized traffic with occasional locks.
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (txq[i].size() < 3 && $urandom_range(0, 99) < 35)
          txq[i].push_back(tx($urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)),
                              8'($urandom), 16'(16'h0100 + $urandom_range(0, 31))));
      end
      idle_lock = 4'($urandom);
      step();
    end
    idle_lock = 4'b0000;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
